// File: rtl/can_rx.sv
// can_rx: serial receiver for the CANtroller single-wire frame format.
// One bus bit is sampled per clk. Finds SOF, deserialises ID, control bits,
// DLC and data bytes into shadow registers, and publishes a complete frame
// on the RX_* registers with a one-cycle RX_VALID strobe. Malformed frames
// (control bit set, DLC > 8, dominant end bit) are dropped with RX_ERR.
//
// Ports:
//   clk      - clock, one bus bit per cycle
//   rst      - synchronous active-high reset
//   init     - synchronous active-high reset, same effect as rst
//   bit_in   - serial line (0 dominant, 1 recessive)
//   RX_ID    - ID of the last good frame
//   RX_DLC   - DLC of the last good frame
//   RX_DATA  - data bytes of the last good frame, byte 0 first received
//   RX_VALID - one-cycle strobe: new frame on RX_ID/RX_DLC/RX_DATA
//   RX_BUSY  - frame reception in progress
//   RX_ERR   - one-cycle strobe: current frame discarded
module can_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        bit_in,
    output logic [10:0] RX_ID,
    output logic [3:0]  RX_DLC,
    output logic [7:0]  RX_DATA [7:0],
    output logic        RX_VALID,
    output logic        RX_BUSY,
    output logic        RX_ERR
);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_ID,
        S_CTRL,
        S_DLC,
        S_DATA,
        S_END
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;       // bit position within current field
    logic [10:0]       id_sh;
    logic [3:0]        dlc_sh;
    logic [7:0][7:0]   data_sh;
    logic              commit, err;
    logic [3:0]        dlc_full;           // DLC including the bit being sampled
    logic [5:0]        last_bit;           // index of the final data bit

    assign dlc_full = {dlc_sh[2:0], bit_in};
    // DATA is only entered with DLC 1..8, so DLC*8-1 always fits in 6 bits.
    assign last_bit = 6'({dlc_sh, 3'b000} - 7'd1);
    assign RX_BUSY  = (state_q != S_WAIT_IDLE) && (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 6'd1;
        commit  = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (bit_in) state_d = S_IDLE;
            end
            S_IDLE: begin
                cnt_d = '0;
                if (!bit_in) state_d = S_ID;
            end
            S_ID: begin
                if (cnt_q == 6'd10) begin
                    state_d = S_CTRL;
                    cnt_d   = '0;
                end
            end
            S_CTRL: begin
                if (bit_in) begin
                    err     = 1'b1;
                    state_d = S_WAIT_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 6'd2) begin
                    state_d = S_DLC;
                    cnt_d   = '0;
                end
            end
            S_DLC: begin
                if (cnt_q == 6'd3) begin
                    cnt_d = '0;
                    if (dlc_full > 4'd8) begin
                        err     = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end else if (dlc_full == 4'd0) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == last_bit) begin
                    state_d = S_END;
                    cnt_d   = '0;
                end
            end
            S_END: begin
                cnt_d = '0;
                if (bit_in) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    err     = 1'b1;
                    state_d = S_WAIT_IDLE;
                end
            end
            default: begin
                state_d = S_WAIT_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || init) begin
            state_q  <= S_WAIT_IDLE;
            cnt_q    <= '0;
            id_sh    <= '0;
            dlc_sh   <= '0;
            data_sh  <= '0;
            RX_ID    <= '0;
            RX_DLC   <= '0;
            RX_VALID <= 1'b0;
            RX_ERR   <= 1'b0;
            for (int i = 0; i < 8; i++) RX_DATA[i] <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            RX_VALID <= commit;
            RX_ERR   <= err;
            case (state_q)
                S_ID:    id_sh  <= {id_sh[9:0], bit_in};
                S_DLC:   dlc_sh <= {dlc_sh[2:0], bit_in};
                S_DATA:  data_sh[cnt_q[5:3]] <= {data_sh[cnt_q[5:3]][6:0], bit_in};
                default: ;
            endcase
            if (commit) begin
                RX_ID  <= id_sh;
                RX_DLC <= dlc_sh;
                // Unused byte slots still hold stale shadow bits; blank them.
                for (int i = 0; i < 8; i++)
                    RX_DATA[i] <= (4'(i) < dlc_sh) ? data_sh[i] : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_can_rx.sv
// Self-checking bench for can_rx. Frames are built as bit queues from their
// field values; expected outputs and strobe timing come from the frame
// format (SOF + 11 + 3 + 4 + 8*DLC + end bit).
module tb_can_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init = 1'b0;
    logic        bit_in = 1'b1;
    logic [10:0] RX_ID;
    logic [3:0]  RX_DLC;
    logic [7:0]  RX_DATA [7:0];
    logic        RX_VALID, RX_BUSY, RX_ERR;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_valid = 0, n_err = 0, n_busy = 0;
    int valid_cyc = -1, err_cyc = -1, sof = 0;
    bit fr[$];
    bit fr_start;

    always #5 clk = ~clk;

    can_rx dut (
        .clk(clk), .rst(rst), .init(init), .bit_in(bit_in),
        .RX_ID(RX_ID), .RX_DLC(RX_DLC), .RX_DATA(RX_DATA),
        .RX_VALID(RX_VALID), .RX_BUSY(RX_BUSY), .RX_ERR(RX_ERR)
    );

    // One clock; observe outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (RX_VALID) begin n_valid++; valid_cyc = cyc; end
        if (RX_ERR)   begin n_err++;   err_cyc   = cyc; end
        if (RX_BUSY)  n_busy++;
    endtask

    task automatic idle(input logic b, input int n);
        for (int i = 0; i < n; i++) begin bit_in = b; tick(); end
    endtask

    task automatic build(input logic [10:0] id, input logic [2:0] ctrl, input logic [3:0] dlc,
                         input logic [7:0][7:0] d, input int nbytes, input logic endb);
        fr.delete();
        fr.push_back(1'b0);
        for (int b = 10; b >= 0; b--) fr.push_back(id[b]);
        for (int b = 2; b >= 0; b--)  fr.push_back(ctrl[b]);
        for (int b = 3; b >= 0; b--)  fr.push_back(dlc[b]);
        for (int i = 0; i < nbytes; i++)
            for (int b = 7; b >= 0; b--) fr.push_back(d[i][b]);
        fr.push_back(endb);
        fr_start = 1'b1;
    endtask

    // Send the next n bits of the built frame; remember the SOF cycle.
    task automatic send(input int n);
        for (int i = 0; i < n && fr.size() > 0; i++) begin
            bit_in = fr.pop_front();
            tick();
            if (fr_start) begin sof = cyc; fr_start = 1'b0; end
        end
        bit_in = 1'b1;
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0][7:0] d, input logic [3:0] dlc, input int i);
        return (i < int'(dlc)) ? d[i] : 8'h00;
    endfunction

    function automatic logic [7:0][7:0] rand_data();
        logic [7:0][7:0] d;
        for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
        return d;
    endfunction

    task automatic test_reset();
        rst = 1'b1; bit_in = 1'b0; tick(); rst = 1'b0;
        n_chk++; if (RX_ID !== 11'h0) begin n_fail++; $display("FAIL reset_id got %h want 000", RX_ID); end
        n_chk++; if (RX_DLC !== 4'h0) begin n_fail++; $display("FAIL reset_dlc got %h want 0", RX_DLC); end
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (RX_DATA[i] !== 8'h00) begin n_fail++; $display("FAIL reset_data[%0d] got %h want 00", i, RX_DATA[i]); end
        end
        n_chk++; if ({RX_VALID, RX_BUSY, RX_ERR} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes got v%b b%b e%b want 000", RX_VALID, RX_BUSY, RX_ERR); end
    endtask

    task automatic test_basic();
        logic [7:0][7:0] d = '0;
        int v0, b0;
        d[0] = 8'hA5; d[1] = 8'h3C;
        idle(1'b1, 2);
        build(11'h123, 3'b000, 4'd2, d, 2, 1'b1);
        v0 = n_valid; b0 = n_busy;
        send(fr.size());
        n_chk++; if (n_valid - v0 !== 1 || valid_cyc !== sof + 35) begin
            n_fail++; $display("FAIL basic_valid_time got n=%0d at %0d want 1 at %0d", n_valid - v0, valid_cyc, sof + 35); end
        n_chk++; if (n_busy - b0 !== 35) begin n_fail++; $display("FAIL basic_busy got %0d want 35", n_busy - b0); end
        n_chk++; if (RX_ID !== 11'h123 || RX_DLC !== 4'd2) begin
            n_fail++; $display("FAIL basic_id_dlc got %h/%0d want 123/2", RX_ID, RX_DLC); end
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (RX_DATA[i] !== exp_byte(d, 4'd2, i)) begin
                n_fail++; $display("FAIL basic_data[%0d] got %h want %h", i, RX_DATA[i], exp_byte(d, 4'd2, i)); end
        end
        idle(1'b1, 1);
        n_chk++; if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL basic_valid_width got %b want 0", RX_VALID); end
    endtask

    task automatic test_back_to_back();
        logic [7:0][7:0] d = '0;
        int v1;
        for (int i = 0; i < 8; i++) d[i] = 8'(i + 1);
        build(11'h7FF, 3'b000, 4'd0, d, 0, 1'b1);
        send(fr.size());
        v1 = valid_cyc;
        n_chk++; if (valid_cyc !== sof + 19 || RX_ID !== 11'h7FF || RX_DLC !== 4'd0 || RX_DATA[0] !== 8'h00) begin
            n_fail++; $display("FAIL b2b_first got cyc %0d id %h dlc %0d d0 %h want cyc %0d id 7ff dlc 0 d0 00",
                               valid_cyc, RX_ID, RX_DLC, RX_DATA[0], sof + 19); end
        build(11'h001, 3'b000, 4'd8, d, 8, 1'b1);
        send(fr.size() - 1);
        n_chk++; if (RX_ID !== 11'h7FF || RX_DLC !== 4'd0 || RX_DATA[7] !== 8'h00) begin
            n_fail++; $display("FAIL b2b_hold got id %h dlc %0d d7 %h want 7ff 0 00", RX_ID, RX_DLC, RX_DATA[7]); end
        send(1);
        n_chk++; if (valid_cyc - v1 !== 84) begin n_fail++; $display("FAIL b2b_spacing got %0d want 84", valid_cyc - v1); end
        n_chk++; if (RX_ID !== 11'h001 || RX_DLC !== 4'd8) begin
            n_fail++; $display("FAIL b2b_second got %h/%0d want 001/8", RX_ID, RX_DLC); end
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (RX_DATA[i] !== 8'(i + 1)) begin
                n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", i, RX_DATA[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_bad_dlc();
        logic [10:0] id0 = RX_ID;
        logic [3:0]  dlc0 = RX_DLC;
        logic [3:0]  bad = 4'($urandom_range(9, 15));
        int v0 = n_valid, e0 = n_err, b0;
        build(11'($urandom), 3'b000, bad, rand_data(), 8, 1'b1);
        send(19);
        n_chk++; if (n_err - e0 !== 1 || err_cyc !== sof + 18) begin
            n_fail++; $display("FAIL bad_dlc_err got n=%0d at %0d want 1 at %0d (dlc %0d)", n_err - e0, err_cyc, sof + 18, bad); end
        b0 = n_busy;
        idle(1'b0, 30);
        n_chk++; if (n_busy - b0 !== 0 || n_valid !== v0 || n_err - e0 !== 1) begin
            n_fail++; $display("FAIL bad_dlc_rearm got busy %0d valid %0d err %0d want 0 0 1", n_busy - b0, n_valid - v0, n_err - e0); end
        n_chk++; if (RX_ID !== id0 || RX_DLC !== dlc0) begin
            n_fail++; $display("FAIL bad_dlc_hold got %h/%0d want %h/%0d", RX_ID, RX_DLC, id0, dlc0); end
    endtask

    task automatic test_bad_ctrl_end();
        logic [7:0][7:0] d;
        logic [10:0] id;
        logic [3:0]  dlc;
        int v0 = n_valid, e0 = n_err;
        idle(1'b1, 1);
        build(11'h2AA, 3'b010, 4'd3, rand_data(), 3, 1'b1);
        send(14);
        n_chk++; if (n_err - e0 !== 1 || err_cyc !== sof + 13) begin
            n_fail++; $display("FAIL bad_ctrl_err got n=%0d at %0d want 1 at %0d", n_err - e0, err_cyc, sof + 13); end
        idle(1'b0, 3);
        idle(1'b1, 1);
        d = rand_data(); id = 11'($urandom); dlc = 4'($urandom_range(0, 8));
        build(id, 3'b000, dlc, d, int'(dlc), 1'b0);
        send(fr.size());
        n_chk++; if (n_err - e0 !== 2 || err_cyc !== sof + 19 + 8 * int'(dlc) || n_valid !== v0) begin
            n_fail++; $display("FAIL bad_end_err got n=%0d at %0d valid %0d want 2 at %0d valid 0",
                               n_err - e0, err_cyc, n_valid - v0, sof + 19 + 8 * int'(dlc)); end
        idle(1'b1, 1);
        build(id, 3'b000, dlc, d, int'(dlc), 1'b1);
        send(fr.size());
        n_chk++; if (n_valid - v0 !== 1 || valid_cyc !== sof + 19 + 8 * int'(dlc) || RX_ID !== id || RX_DLC !== dlc) begin
            n_fail++; $display("FAIL recover_frame got n=%0d at %0d id %h dlc %0d want 1 at %0d id %h dlc %0d",
                               n_valid - v0, valid_cyc, RX_ID, RX_DLC, sof + 19 + 8 * int'(dlc), id, dlc); end
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (RX_DATA[i] !== exp_byte(d, dlc, i)) begin
                n_fail++; $display("FAIL recover_data[%0d] got %h want %h", i, RX_DATA[i], exp_byte(d, dlc, i)); end
        end
    endtask

    task automatic test_low_line();
        int v0, e0, b0;
        rst = 1'b1; bit_in = 1'b0; tick(); rst = 1'b0;
        v0 = n_valid; e0 = n_err; b0 = n_busy;
        idle(1'b0, 200);
        n_chk++; if (n_busy !== b0 || n_valid !== v0 || n_err !== e0) begin
            n_fail++; $display("FAIL low_line got busy %0d valid %0d err %0d want 0 0 0", n_busy - b0, n_valid - v0, n_err - e0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0][7:0] d = rand_data();
        int v0, e0;
        idle(1'b1, 1);
        build(11'h555, 3'b000, 4'd4, d, 4, 1'b1);
        send(fr.size());
        v0 = n_valid; e0 = n_err;
        build(11'h0F0, 3'b000, 4'd4, d, 4, 1'b1);
        send(29);
        rst = 1'b1; bit_in = 1'b0; tick(); rst = 1'b0;
        n_chk++; if (RX_ID !== 11'h0 || RX_DLC !== 4'h0 || RX_DATA[0] !== 8'h00 || RX_DATA[3] !== 8'h00 ||
                     RX_BUSY !== 1'b0 || n_valid !== v0 || n_err !== e0) begin
            n_fail++; $display("FAIL reset_mid got id %h dlc %0d d0 %h busy %b valid %0d err %0d want all 0",
                               RX_ID, RX_DLC, RX_DATA[0], RX_BUSY, n_valid - v0, n_err - e0); end
        idle(1'b1, 1);
        build(11'h0F0, 3'b000, 4'd4, d, 4, 1'b1);
        send(fr.size());
        n_chk++; if (n_valid - v0 !== 1 || RX_ID !== 11'h0F0 || RX_DATA[3] !== d[3] || RX_DATA[4] !== 8'h00) begin
            n_fail++; $display("FAIL reset_mid_recover got n=%0d id %h d3 %h d4 %h want 1 0f0 %h 00",
                               n_valid - v0, RX_ID, RX_DATA[3], RX_DATA[4], d[3]); end
    endtask

    task automatic test_random();
        logic [7:0][7:0] d;
        logic [10:0] id;
        logic [3:0]  dlc;
        int v0;
        for (int f = 0; f < 25; f++) begin
            idle(1'b1, $urandom_range(0, 2));
            d = rand_data(); id = 11'($urandom); dlc = 4'($urandom_range(0, 8));
            v0 = n_valid;
            build(id, 3'b000, dlc, d, int'(dlc), 1'b1);
            send(fr.size());
            n_chk++; if (n_valid - v0 !== 1 || valid_cyc !== sof + 19 + 8 * int'(dlc) || RX_ID !== id || RX_DLC !== dlc) begin
                n_fail++; $display("FAIL rand_frame%0d got n=%0d at %0d id %h dlc %0d want 1 at %0d id %h dlc %0d",
                                   f, n_valid - v0, valid_cyc, RX_ID, RX_DLC, sof + 19 + 8 * int'(dlc), id, dlc); end
            for (int i = 0; i < 8; i++) begin
                n_chk++; if (RX_DATA[i] !== exp_byte(d, dlc, i)) begin
                    n_fail++; $display("FAIL rand_data%0d[%0d] got %h want %h", f, i, RX_DATA[i], exp_byte(d, dlc, i)); end
            end
        end
        init = 1'b1; tick(); init = 1'b0;
        n_chk++; if (RX_ID !== 11'h0 || RX_DLC !== 4'h0 || RX_DATA[0] !== 8'h00 || RX_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL init_clear got id %h dlc %0d d0 %h busy %b want 0", RX_ID, RX_DLC, RX_DATA[0], RX_BUSY); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_bad_dlc();
        test_bad_ctrl_end();
        test_low_line();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
